// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Program loader that sits ahead of the CPU's instruction memory. It
//   accepts MIPS instruction fields over a valid/ready handshake and packs
//   each bundle into a 32-bit word. The opcode selects the format:
//     op 0   -> R-type {op, rs, rt, rd, shamt, funct}
//     op 2/3 -> J-type {op, target}
//     other  -> I-type {op, rs, rt, imm}
//   Encoded words are buffered in a small FIFO. A three-state issue FSM
//   (IDLE / ISSUE / STALL) then writes them to consecutive word addresses,
//   one word per cycle while the memory is not busy.
//
// Optional feature (compile-time macro ENC_ILLEGAL_CHECK_EN):
//   When defined, opcodes outside the supported MIPS subset are accepted
//   (the handshake completes) but are not buffered, and the sticky err_o is
//   raised. When undefined, every opcode is buffered and err_o is tied to 0.
//
// Parameters:
//   FIFO_DEPTH  encoded-word buffer entries (power of 2, >= 2)
//   ADDR_W      instruction-memory word-address width
//   BASE_ADDR   word address loaded on reset and on start_i
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-low
//   start_i      synchronous restart: flush FIFO, rewind address, clear flags
//   req_valid_i  field bundle valid
//   req_ready_o  FIFO can accept a bundle (not full)
//   op_i .. target_i  instruction fields to encode
//   imem_busy_i  memory cannot take a write this cycle
//   imem_we_o    write strobe, one cycle per word
//   imem_addr_o  word address of the current write
//   imem_data_o  encoded instruction being written
//   count_o      FIFO occupancy
//   err_o        sticky: illegal opcode dropped
//   wrap_o       sticky: write address wrapped past all-ones
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter int unsigned          ADDR_W     = 10,
  parameter logic [ADDR_W-1:0]    BASE_ADDR  = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [5:0]                        op_i,
  input  logic [4:0]                        rs_i,
  input  logic [4:0]                        rt_i,
  input  logic [4:0]                        rd_i,
  input  logic [4:0]                        shamt_i,
  input  logic [5:0]                        funct_i,
  input  logic [15:0]                       imm_i,
  input  logic [25:0]                       target_i,
  input  logic                              imem_busy_i,
  output logic                              imem_we_o,
  output logic [ADDR_W-1:0]                 imem_addr_o,
  output logic [31:0]                       imem_data_o,
  output logic [$clog2(FIFO_DEPTH):0]       count_o,
  output logic                              err_o,
  output logic                              wrap_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } fsmState_t;

  // Pack one field bundle into a MIPS instruction word.
  function automatic logic [31:0] encodeWord(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (op)
      6'd0:       word = {op, rs, rt, rd, shamt, funct};
      6'd2, 6'd3: word = {op, target};
      default:    word = {op, rs, rt, imm};
    endcase
    return word;
  endfunction

`ifdef ENC_ILLEGAL_CHECK_EN
  // Opcodes the downstream control decoder understands.
  function automatic logic isLegalOp(input logic [5:0] op);
    logic legal;
    case (op)
      6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
      6'd8, 6'd11, 6'd13, 6'd15, 6'd35, 6'd43: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction
`endif

  logic [31:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countNext;
  logic [ADDR_W-1:0] wordAddr;
  fsmState_t         state;

  logic [31:0]       encWord_p0;
  logic              accept_p0;
  logic              vld_p0;
  logic              fifoFull;
  logic              popEn;

  // ---- Stage p0: encode at the input and push into the FIFO ----
  assign encWord_p0  = encodeWord(op_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i);
  assign fifoFull    = (count == CNT_W'(FIFO_DEPTH));
  assign req_ready_o = ~fifoFull;
  // A restart swallows any bundle presented in the same cycle.
  assign accept_p0   = req_valid_i & req_ready_o & ~start_i;

`ifdef ENC_ILLEGAL_CHECK_EN
  logic legal_p0;
  logic illegal_p0;
  assign legal_p0   = isLegalOp(op_i);
  assign vld_p0     = accept_p0 & legal_p0;
  assign illegal_p0 = accept_p0 & ~legal_p0;
`else
  assign vld_p0     = accept_p0;
`endif

  // The head is popped only on a cycle that actually issues a write.
  assign popEn     = (state == ISSUE) & ~imem_busy_i & (count != '0) & ~start_i;
  // Simultaneous push and pop leave the occupancy unchanged.
  assign countNext = count + CNT_W'(vld_p0) - CNT_W'(popEn);
  assign count_o   = count;

  // Storage carries no reset: only the pointers and count decide validity.
  always_ff @(posedge clk_i) begin
    if (vld_p0) begin
      fifoMem[wrPtr] <= encWord_p0;
    end
  end

  // ---- Stage p1: issue FSM driving the registered memory write port ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      wordAddr    <= BASE_ADDR;
      imem_we_o   <= 1'b0;
      imem_addr_o <= BASE_ADDR;
      imem_data_o <= '0;
      wrap_o      <= 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
      err_o       <= 1'b0;
`endif
    end else if (start_i) begin
      // Restart wins over push and pop; the last data word is simply left
      // on the bus since the strobe is dropped.
      state       <= IDLE;
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      wordAddr    <= BASE_ADDR;
      imem_we_o   <= 1'b0;
      imem_addr_o <= BASE_ADDR;
      wrap_o      <= 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
      err_o       <= 1'b0;
`endif
    end else begin
      if (vld_p0) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= countNext;
`ifdef ENC_ILLEGAL_CHECK_EN
      if (illegal_p0) begin
        err_o <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          imem_we_o <= 1'b0;
          if (count != '0) begin
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (imem_busy_i) begin
            imem_we_o <= 1'b0;
            state     <= STALL;
          end else if (count != '0) begin
            imem_we_o   <= 1'b1;
            imem_data_o <= fifoMem[rdPtr];
            imem_addr_o <= wordAddr;
            wordAddr    <= wordAddr + ADDR_W'(1);
            // Writing the all-ones address means the pointer rolls to 0.
            if (&wordAddr) begin
              wrap_o <= 1'b1;
            end
            // Stay in ISSUE if a push refills the entry being popped.
            if (countNext == '0) begin
              state <= IDLE;
            end
          end else begin
            imem_we_o <= 1'b0;
            state     <= IDLE;
          end
        end

        STALL: begin
          imem_we_o <= 1'b0;
          if (!imem_busy_i) begin
            state <= ISSUE;
          end
        end

        default: begin
          imem_we_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifndef ENC_ILLEGAL_CHECK_EN
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
`timescale 1ns/1ps
module tb_instr_encoder_loader;

  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 5;
  localparam int CNT_W      = 3;
  localparam logic [ADDR_W-1:0] BASE_ADDR = '0;
  localparam int ADDR_SPAN  = 2 ** ADDR_W;
  localparam int LEGAL_OPS [13] = '{0, 2, 3, 4, 5, 6, 7, 8, 11, 13, 15, 35, 43};

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [5:0]        op_i = '0;
  logic [4:0]        rs_i = '0;
  logic [4:0]        rt_i = '0;
  logic [4:0]        rd_i = '0;
  logic [4:0]        shamt_i = '0;
  logic [5:0]        funct_i = '0;
  logic [15:0]       imm_i = '0;
  logic [25:0]       target_i = '0;
  logic              imem_busy_i = 1'b0;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic [CNT_W-1:0]  count_o;
  logic              err_o;
  logic              wrap_o;

  instr_encoder_loader #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .op_i       (op_i),
    .rs_i       (rs_i),
    .rt_i       (rt_i),
    .rd_i       (rd_i),
    .shamt_i    (shamt_i),
    .funct_i    (funct_i),
    .imm_i      (imm_i),
    .target_i   (target_i),
    .imem_busy_i(imem_busy_i),
    .imem_we_o  (imem_we_o),
    .imem_addr_o(imem_addr_o),
    .imem_data_o(imem_data_o),
    .count_o    (count_o),
    .err_o      (err_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc = cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  wr_t         expHead;
  logic [31:0] logData[$];
  int          logAddr[$];
  int          logCyc[$];
  int          expAddr = 0;
  bit          expErr = 1'b0;
  bit          expWrap = 1'b0;
  bit          stopBusy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference encoding built from field weights rather than bit packing.
  function automatic logic [31:0] refEncode(input int op, rs, rt, rd, sh, fn, imm, tgt);
    longint w;
    if (op == 0)
      w = longint'(op) * 64'd67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536
        + longint'(rd) * 2048 + longint'(sh) * 64 + longint'(fn);
    else if (op == 2 || op == 3)
      w = longint'(op) * 64'd67108864 + longint'(tgt);
    else
      w = longint'(op) * 64'd67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536
        + longint'(imm);
    return w[31:0];
  endfunction

  function automatic bit refLegal(input int op);
`ifdef ENC_ILLEGAL_CHECK_EN
    foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) return 1'b1;
    return 1'b0;
`else
    return (op >= 0);
`endif
  endfunction

  function automatic int randOp(input bit allowIllegal);
    int idx;
    if (allowIllegal && $urandom_range(0, 4) == 0) return int'($urandom_range(0, 63));
    idx = int'($urandom_range(0, 12));
    return LEGAL_OPS[idx];
  endfunction

  task automatic modelFlush();
    expQ.delete();
    expAddr = int'(BASE_ADDR);
    expErr  = 1'b0;
    expWrap = 1'b0;
  endtask

  // Drive one bundle and hold it until the handshake edge.
  task automatic send(input int op, rs, rt, rd, sh, fn, imm, tgt);
    int budget;
    wr_t e;
    budget = 0;
    @(negedge clk_i);
    op_i = 6'(op); rs_i = 5'(rs); rt_i = 5'(rt); rd_i = 5'(rd);
    shamt_i = 5'(sh); funct_i = 6'(fn); imm_i = 16'(imm); target_i = 26'(tgt);
    req_valid_i = 1'b1;
    while (!req_ready_o) begin
      @(negedge clk_i);
      budget++;
      if (budget > 500) begin
        checks++; failures++;
        $display("FAIL send_timeout actual=ready_low required=ready_high");
        req_valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk_i);
    if (refLegal(op)) begin
      e.addr = expAddr;
      e.data = refEncode(op, rs, rt, rd, sh, fn, imm, tgt);
      expQ.push_back(e);
      if (expAddr == ADDR_SPAN - 1) expWrap = 1'b1;
      expAddr = (expAddr + 1) % ADDR_SPAN;
    end else begin
      expErr = 1'b1;
    end
  endtask

  task automatic sendRand(input bit allowIllegal);
    send(randOp(allowIllegal), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
         int'($urandom_range(0, 65535)), int'($urandom_range(0, 67108863)));
  endtask

  task automatic idle();
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Restart pulse with a live request presented alongside it.
  task automatic startPulse();
    @(negedge clk_i);
    start_i = 1'b1;
    op_i = 6'd8; rs_i = 5'($urandom_range(0, 31)); rt_i = 5'($urandom_range(0, 31));
    imm_i = 16'($urandom_range(0, 65535));
    req_valid_i = 1'b1;
    @(posedge clk_i);
    modelFlush();
    @(negedge clk_i);
    start_i = 1'b0;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || count_o != '0 || imem_we_o) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_done", (n < 300) ? 64'd1 : 64'd0, 64'd1);
    repeat (2) @(negedge clk_i);
  endtask

  // Scoreboard monitor: every write strobe consumes the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_i && imem_we_o) begin
      logData.push_back(imem_data_o);
      logAddr.push_back(int'(imem_addr_o));
      logCyc.push_back(cyc);
      if (expQ.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=0x%0h@%0d required=no_write", imem_data_o, imem_addr_o);
      end else begin
        expHead = expQ.pop_front();
        check("wr_data", 64'(imem_data_o), 64'(expHead.data));
        check("wr_addr", 64'(imem_addr_o), 64'(expHead.addr));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb;
    modelFlush();
    repeat (3) @(negedge clk_i);
    check("rst_ready", req_ready_o, 1);
    check("rst_we",    imem_we_o, 0);
    check("rst_addr",  imem_addr_o, BASE_ADDR);
    check("rst_data",  imem_data_o, 0);
    check("rst_count", count_o, 0);
    check("rst_err",   err_o, 0);
    check("rst_wrap",  wrap_o, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // R-type latency and exact word
    send(0, 1, 2, 3, 0, 32, 0, 0);
    @(negedge clk_i); req_valid_i = 1'b0;
    check("t1_we_n0", imem_we_o, 0);
    @(negedge clk_i);
    check("t1_we_n1", imem_we_o, 0);
    @(negedge clk_i);
    check("t1_we_n2",   imem_we_o, 1);
    check("t1_data",    imem_data_o, 32'h00221820);
    check("t1_addr",    imem_addr_o, BASE_ADDR);
    @(negedge clk_i);
    check("t1_we_once", imem_we_o, 0);
    drain();

    // ADDI then J at addresses 0 and 1
    startPulse();
    lb = logData.size();
    send(8, 0, 8, 0, 0, 0, 16'hFFFF, 0);
    send(2, 0, 0, 0, 0, 0, 0, 26'h100);
    idle();
    drain();
    check("t2_nwr", logData.size() - lb, 2);
    if (logData.size() >= lb + 2) begin
      check("t2_data0", logData[lb],     32'h2008FFFF);
      check("t2_addr0", logAddr[lb],     0);
      check("t2_data1", logData[lb + 1], 32'h08000100);
      check("t2_addr1", logAddr[lb + 1], 1);
    end

    // Backpressure: full FIFO under busy, then burst release
    startPulse();
    @(negedge clk_i); imem_busy_i = 1'b1;
    lb = logData.size();
    repeat (4) sendRand(1'b0);
    idle();
    @(negedge clk_i);
    check("t3_count_full", count_o, 4);
    check("t3_ready_low",  req_ready_o, 0);
    check("t3_no_writes",  logData.size() - lb, 0);
    fork
      begin
        sendRand(1'b0);
        sendRand(1'b0);
        idle();
      end
      begin
        @(negedge clk_i);
        imem_busy_i = 1'b0;
      end
    join
    drain();
    check("t3_nwr", logData.size() - lb, 6);
    if (logData.size() >= lb + 4) begin
      for (int i = 0; i < 3; i++)
        check("t3_back2back", logCyc[lb + i + 1] - logCyc[lb + i], 1);
    end

    // Address wrap
    startPulse();
    repeat (ADDR_SPAN - 1) sendRand(1'b0);
    idle();
    drain();
    check("t4_wrap_before", wrap_o, 0);
    lb = logData.size();
    sendRand(1'b0);
    sendRand(1'b0);
    idle();
    drain();
    check("t4_wrap_after", wrap_o, 1);
    check("t4_wrap_model", wrap_o, expWrap);
    if (logData.size() >= lb + 2) begin
      check("t4_addr_ones", logAddr[lb],     ADDR_SPAN - 1);
      check("t4_addr_zero", logAddr[lb + 1], 0);
    end

    // Opcode 0x3F
    lb = logData.size();
    send(63, 3, 4, 0, 0, 0, 16'h1234, 0);
    idle();
    drain();
`ifdef ENC_ILLEGAL_CHECK_EN
    check("t5_err",  err_o, 1);
    check("t5_nwr",  logData.size() - lb, 0);
`else
    check("t5_err",  err_o, 0);
    check("t5_nwr",  logData.size() - lb, 1);
    if (logData.size() > lb) check("t5_data", logData[lb], 32'hFC641234);
`endif
    check("t5_err_model", err_o, expErr);

    // Restart with buffered words under busy
    @(negedge clk_i); imem_busy_i = 1'b1;
    repeat (3) sendRand(1'b0);
    idle();
    repeat (2) @(negedge clk_i);
    check("t6_count_pre", count_o, 3);
    startPulse();
    check("t6_count", count_o, 0);
    check("t6_addr",  imem_addr_o, BASE_ADDR);
    check("t6_err",   err_o, 0);
    check("t6_wrap",  wrap_o, 0);
    check("t6_we",    imem_we_o, 0);
    imem_busy_i = 1'b0;
    lb = logData.size();
    repeat (10) @(negedge clk_i);
    check("t6_no_writes", logData.size() - lb, 0);

    // Randomized traffic with random backpressure and illegal opcodes
    startPulse();
    stopBusy = 1'b0;
    fork
      begin
        while (!stopBusy) begin
          @(negedge clk_i);
          imem_busy_i = ($urandom_range(0, 3) == 0);
        end
      end
      begin
        for (int k = 0; k < 80; k++) begin
          sendRand(1'b1);
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
          end
        end
        idle();
        stopBusy = 1'b1;
      end
    join
    imem_busy_i = 1'b0;
    drain();
    check("rnd_err",  err_o, expErr);
    check("rnd_wrap", wrap_o, expWrap);

    // Asynchronous reset mid-operation
    @(negedge clk_i); imem_busy_i = 1'b1;
    repeat (3) sendRand(1'b0);
    idle();
    #2 rst_i = 1'b0;
    #1;
    modelFlush();
    check("arst_count", count_o, 0);
    check("arst_ready", req_ready_o, 1);
    check("arst_we",    imem_we_o, 0);
    check("arst_addr",  imem_addr_o, BASE_ADDR);
    @(negedge clk_i);
    rst_i = 1'b1;
    imem_busy_i = 1'b0;
    lb = logData.size();
    repeat (10) @(negedge clk_i);
    check("arst_no_writes", logData.size() - lb, 0);
    check("final_queue_empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
